// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and fixed
// instruction/address constants.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        FAULT  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, next-PC selection and F/D pipeline registers,
// sequenced by a small FSM that covers the memory read latency after reset.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         Stall_En,
    input  logic         Flush_D,
    input  logic         PC_Src_E,
    input  logic [31:0]  PC_Target_E,
    output logic [31:0]  PC_F,
    output logic [31:0]  PC_D,
    output logic [31:0]  PC_Plus4_D,
    output logic         Valid_D,
    output logic         Fault,
    output logic [31:0]  Fetch_Count,
    output fetch_state_t state_dbg
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_f_q, pc_f_d;
    logic [31:0]  pc_d_q, pc_d_d;
    logic [31:0]  pc_plus4_d_q, pc_plus4_d_d;
    logic         valid_d_q, valid_d_d;
    logic [31:0]  count_q, count_d;
    logic [31:0]  pc_f_plus4;

    // Handshake-free stage: Stall_En holds F and F/D, PC_Src_E redirects and
    // always wins over a stall, Flush_D kills the decode slot and wins over a stall.
    always_comb begin
        state_d      = state_q;
        pc_f_d       = pc_f_q;
        pc_d_d       = pc_d_q;
        pc_plus4_d_d = pc_plus4_d_q;
        valid_d_d    = valid_d_q;
        count_d      = count_q;
        pc_f_plus4   = pc_f_q + 32'd4;

        unique case (state_q)
            RESET: begin
                state_d   = WARMUP;
                pc_f_d    = RESET_PC;
                valid_d_d = 1'b0;
            end
            WARMUP: begin
                state_d   = RUN;
                pc_f_d    = RESET_PC;
                valid_d_d = 1'b0;
            end
            RUN: begin
                // A misaligned target is never fetched; PC_F keeps its last value.
                if (PC_Src_E) begin
                    if (PC_Target_E[1:0] != 2'b00) begin
                        state_d = FAULT;
                    end else begin
                        pc_f_d = PC_Target_E;
                    end
                end else if (!Stall_En) begin
                    pc_f_d = pc_f_plus4;
                end
                if (!Stall_En) begin
                    pc_d_d       = pc_f_q;
                    pc_plus4_d_d = pc_f_plus4;
                    valid_d_d    = 1'b1;
                end
                if (Flush_D || PC_Src_E) begin
                    valid_d_d = 1'b0;
                end
                if (pc_f_d != pc_f_q) begin
                    count_d = count_q + 32'd1;
                end
            end
            FAULT: begin
                valid_d_d = 1'b0;
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= RESET;
            pc_f_q       <= RESET_PC;
            pc_d_q       <= 32'd0;
            pc_plus4_d_q <= 32'd0;
            valid_d_q    <= 1'b0;
            count_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_f_q       <= pc_f_d;
            pc_d_q       <= pc_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
            count_q      <= count_d;
        end
    end

    assign PC_F        = pc_f_q;
    assign PC_D        = pc_d_q;
    assign PC_Plus4_D  = pc_plus4_d_q;
    assign Valid_D     = valid_d_q;
    assign Fault       = (state_q == FAULT);
    assign Fetch_Count = count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle inputs and expected
// register values, followed by a hand-written sticky-fault sequence.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    // ---------------- clock / reset ----------------
    logic         CLK = 1'b0;
    logic         RST;
    logic         Stall_En;
    logic         Flush_D;
    logic         PC_Src_E;
    logic [31:0]  PC_Target_E;
    logic [31:0]  PC_F;
    logic [31:0]  PC_D;
    logic [31:0]  PC_Plus4_D;
    logic         Valid_D;
    logic         Fault;
    logic [31:0]  Fetch_Count;
    fetch_state_t state_dbg;

    always #5 CLK = ~CLK;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Stall_En    (Stall_En),
        .Flush_D     (Flush_D),
        .PC_Src_E    (PC_Src_E),
        .PC_Target_E (PC_Target_E),
        .PC_F        (PC_F),
        .PC_D        (PC_D),
        .PC_Plus4_D  (PC_Plus4_D),
        .Valid_D     (Valid_D),
        .Fault       (Fault),
        .Fetch_Count (Fetch_Count),
        .state_dbg   (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         rst;
        logic         stall;
        logic         flush;
        logic         src;
        logic [31:0]  tgt;
        logic [31:0]  pc_f;
        logic [31:0]  pc_d;
        logic [31:0]  p4;
        logic         valid;
        logic         fault;
        logic [31:0]  cnt;
        fetch_state_t st;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stall, input logic flush, input logic src,
                       input logic [31:0] tgt, input logic [31:0] pc_f, input logic [31:0] pc_d,
                       input logic [31:0] p4, input logic valid, input logic fault,
                       input logic [31:0] cnt, input fetch_state_t st);
        vec_t v;
        v.rst = rst; v.stall = stall; v.flush = flush; v.src = src; v.tgt = tgt;
        v.pc_f = pc_f; v.pc_d = pc_d; v.p4 = p4; v.valid = valid; v.fault = fault;
        v.cnt = cnt; v.st = st;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic stall, input logic flush,
                         input logic src, input logic [31:0] tgt);
        RST = rst; Stall_En = stall; Flush_D = flush; PC_Src_E = src; PC_Target_E = tgt;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc_f, input logic [31:0] pc_d,
                             input logic [31:0] p4, input logic valid, input logic fault,
                             input logic [31:0] cnt, input fetch_state_t st);
        check({tag, " pc_f"},  PC_F, pc_f);
        check({tag, " pc_d"},  PC_D, pc_d);
        check({tag, " pc_p4"}, PC_Plus4_D, p4);
        check({tag, " valid"}, {31'd0, Valid_D}, {31'd0, valid});
        check({tag, " fault"}, {31'd0, Fault}, {31'd0, fault});
        check({tag, " count"}, Fetch_Count, cnt);
        check({tag, " state"}, {30'd0, state_dbg}, {30'd0, st});
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        //   rst stall flush src target         pc_f           pc_d           pc_plus4       v  f  cnt state
        // reset held three cycles, then release and warm up
        add(1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0,  RESET);
        add(1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0,  RESET);
        add(1, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0,  RESET);
        add(0, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0,  WARMUP);
        add(0, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h4,         32'h0,         32'h4,         1, 0, 1,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h8,         32'h4,         32'h8,         1, 0, 2,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'hC,         32'h8,         32'hC,         1, 0, 3,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h10,        32'hC,         32'h10,        1, 0, 4,  RUN);
        // two stall cycles at PC_F = 0x10
        add(0, 1, 0, 0, 32'h0,          32'h10,        32'hC,         32'h10,        1, 0, 4,  RUN);
        add(0, 1, 0, 0, 32'h0,          32'h10,        32'hC,         32'h10,        1, 0, 4,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h14,        32'h10,        32'h14,        1, 0, 5,  RUN);
        // flush together with stall
        add(0, 1, 1, 0, 32'h0,          32'h14,        32'h10,        32'h14,        0, 0, 5,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h18,        32'h14,        32'h18,        1, 0, 6,  RUN);
        // redirect beats stall
        add(0, 1, 0, 1, 32'h40,         32'h40,        32'h14,        32'h18,        0, 0, 7,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h44,        32'h40,        32'h44,        1, 0, 8,  RUN);
        // redirect to the top word, then wrap
        add(0, 0, 0, 1, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 32'h44,        32'h48,        0, 0, 9,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h0,         32'hFFFF_FFFC, 32'h0,         1, 0, 10, RUN);
        add(0, 0, 0, 0, 32'h0,          32'h4,         32'h0,         32'h4,         1, 0, 11, RUN);
        // misaligned target: PC_F frozen, fault sticky
        add(0, 0, 0, 1, 32'h42,         32'h4,         32'h4,         32'h8,         0, 1, 11, FAULT);
        add(0, 0, 0, 0, 32'h0,          32'h4,         32'h4,         32'h8,         0, 1, 11, FAULT);
        add(0, 0, 0, 1, 32'h80,         32'h4,         32'h4,         32'h8,         0, 1, 11, FAULT);
        // reset overrides a concurrent redirect
        add(1, 0, 0, 1, 32'h80,         32'h0,         32'h0,         32'h0,         0, 0, 0,  RESET);
        add(0, 0, 0, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0,  WARMUP);
        add(0, 0, 1, 0, 32'h0,          32'h0,         32'h0,         32'h0,         0, 0, 0,  RUN);
        add(0, 0, 0, 0, 32'h0,          32'h4,         32'h0,         32'h4,         1, 0, 1,  RUN);
        // flush alone: fetch advances, decode slot killed
        add(0, 0, 1, 0, 32'h0,          32'h8,         32'h4,         32'h8,         0, 0, 2,  RUN);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].src, vecs[i].tgt);
            @(posedge CLK);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].pc_f, vecs[i].pc_d, vecs[i].p4,
                      vecs[i].valid, vecs[i].fault, vecs[i].cnt, vecs[i].st);
        end

        // misaligned redirect under stall, then a burst of mixed inputs in FAULT
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0043);
        @(posedge CLK);
        #1;
        check_all("fault_entry", 32'h8, 32'h4, 32'h8, 1'b0, 1'b1, 32'd2, FAULT);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, i[0], i[1], ~i[0], 32'h100 + 32'(i * 4));
            @(posedge CLK);
            #1;
            check($sformatf("fault_hold%0d pc_f", i), PC_F, 32'h8);
            check($sformatf("fault_hold%0d fault", i), {31'd0, Fault}, 32'd1);
            check($sformatf("fault_hold%0d valid", i), {31'd0, Valid_D}, 32'd0);
            check($sformatf("fault_hold%0d count", i), Fetch_Count, 32'd2);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge CLK);
        #1;
        check_all("fault_clear", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, RESET);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
